// File: rtl/flag_track_unit_pkg.sv
// flag_track_unit_pkg: shared flag indices, state encoding and default widths
package flag_track_unit_pkg;
    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_W  = 2;
    localparam int CNT_W   = 16;
    typedef enum logic {VALID = 1'b0, PENDING = 1'b1} state_t;
endpackage

// File: rtl/flag_track_unit_if.sv
// flag_track_unit_if: EX-stage flag/branch signals between pipeline and flag tracker
interface flag_track_unit_if #(parameter int FLAG_W = 2, parameter int CNT_W = 16);
    logic              ex_valid;
    logic              ex_setflag;
    logic              ex_multi;
    logic              mc_done;
    logic [FLAG_W-1:0] alu_flag;
    logic              ex_branch;
    logic              ex_cmp;
    logic              kill;
    logic              stall_in;
    logic [FLAG_W-1:0] flag_old;
    logic              use_old;
    logic              flag_stall;
    logic              flag_pending;
    logic [CNT_W-1:0]  stall_cnt;
    modport master (
        output ex_valid, ex_setflag, ex_multi, mc_done, alu_flag, ex_branch, ex_cmp, kill, stall_in,
        input  flag_old, use_old, flag_stall, flag_pending, stall_cnt
    );
    modport slave (
        input  ex_valid, ex_setflag, ex_multi, mc_done, alu_flag, ex_branch, ex_cmp, kill, stall_in,
        output flag_old, use_old, flag_stall, flag_pending, stall_cnt
    );
endinterface

// File: rtl/flag_track_unit.sv
// flag_track_unit: architectural flag register with multi-cycle writer tracking and branch flag hazard stall
module flag_track_unit
    import flag_track_unit_pkg::*;
#(
    parameter int FLAG_W = flag_track_unit_pkg::FLAG_W,
    parameter int CNT_W  = flag_track_unit_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    flag_track_unit_if.slave  bus
);
    state_t            r_state, w_state_nxt;
    logic [FLAG_W-1:0] r_flag, w_flag_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_stall;
    logic              w_commit;

    assign w_stall  = bus.ex_valid & (r_state == PENDING) &
                      ((bus.ex_branch & ~bus.ex_cmp) | bus.ex_setflag);
    assign w_commit = bus.ex_valid & ~bus.stall_in & ~w_stall;

    assign bus.flag_old     = r_flag;
    assign bus.use_old      = bus.ex_valid & bus.ex_branch & ~bus.ex_cmp;
    assign bus.flag_stall   = w_stall;
    assign bus.flag_pending = (r_state == PENDING);
    assign bus.stall_cnt    = r_cnt;

    // state, flag register and stall counter update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= VALID;
            r_flag  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flag  <= w_flag_nxt;
            r_cnt   <= r_cnt + CNT_W'(w_stall);
        end
    end

    // next state and flag: kill in PENDING drops a same-cycle late result
    always_comb begin
        w_state_nxt = r_state;
        w_flag_nxt  = r_flag;
        if (r_state == PENDING) begin
            if (bus.kill) begin
                w_state_nxt = VALID;
            end else if (bus.mc_done) begin
                w_state_nxt = VALID;
                w_flag_nxt  = bus.alu_flag;
            end
        end else if (w_commit && bus.ex_setflag) begin
            if (bus.ex_multi) w_state_nxt = PENDING;
            else              w_flag_nxt  = bus.alu_flag;
        end
    end
endmodule

// File: tb/tb_flag_track_unit.sv
// tb_flag_track_unit: directed and random checks of flag_track_unit against a rule-level model
module tb_flag_track_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    flag_track_unit_if #(.FLAG_W(2), .CNT_W(16)) bus ();
    flag_track_unit #(.FLAG_W(2), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [1:0]  m_flag;
    bit          m_pend;
    logic [15:0] m_cnt;
    logic        last_use, last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit sf, input bit mu, input bit mc, input logic [1:0] alu,
                        input bit br, input bit cmp, input bit kl, input bit si, input bit rs);
        bit e_use, e_stall, com;
        @(negedge clk);
        reset = rs;
        bus.ex_valid = v; bus.ex_setflag = sf; bus.ex_multi = mu; bus.mc_done = mc;
        bus.alu_flag = alu; bus.ex_branch = br; bus.ex_cmp = cmp; bus.kill = kl; bus.stall_in = si;
        e_use   = v && br && !cmp;
        e_stall = v && m_pend && ((br && !cmp) || sf);
        com     = v && !si && !e_stall;
        #1;
        last_use   = bus.use_old;
        last_stall = bus.flag_stall;
        chk("use_old", 32'(bus.use_old), 32'(e_use));
        chk("flag_stall", 32'(bus.flag_stall), 32'(e_stall));
        @(posedge clk);
        if (rs) begin
            m_flag = 2'b00; m_pend = 0; m_cnt = 16'd0;
        end else begin
            if (e_stall) m_cnt = m_cnt + 16'd1;
            if (m_pend) begin
                if (kl) m_pend = 0;
                else if (mc) begin m_flag = alu; m_pend = 0; end
            end else if (com && sf) begin
                if (mu) m_pend = 1;
                else m_flag = alu;
            end
        end
        #1;
        chk("flag_old", 32'(bus.flag_old), 32'(m_flag));
        chk("flag_pending", 32'(bus.flag_pending), 32'(m_pend));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    endtask

    initial begin
        m_flag = 2'b00; m_pend = 0; m_cnt = 16'd0;
        step(0,0,0,0,2'b00,0,0,0,0,1);
        chk("rst_flag", 32'(bus.flag_old), 32'h0);
        chk("rst_pend", 32'(bus.flag_pending), 32'h0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
        step(1,1,0,0,2'b01,0,0,0,0,0);
        chk("single_write", 32'(bus.flag_old), 32'h1);
        step(1,0,0,0,2'b00,1,0,0,0,0);
        chk("b2b_use_old", 32'(last_use), 32'h1);
        chk("b2b_no_stall", 32'(last_stall), 32'h0);
        step(1,1,1,0,2'b11,0,0,0,0,0);
        chk("multi_pend", 32'(bus.flag_pending), 32'h1);
        chk("multi_hold", 32'(bus.flag_old), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,0,2'b00,1,0,0,0,0);
            chk("dep_stall", 32'(last_stall), 32'h1);
        end
        step(1,0,0,1,2'b10,1,0,0,0,0);
        chk("mc_cycle_stall", 32'(last_stall), 32'h1);
        chk("mc_write", 32'(bus.flag_old), 32'h2);
        step(1,0,0,0,2'b00,1,0,0,0,0);
        chk("release", 32'(last_stall), 32'h0);
        chk("stall_count", 32'(bus.stall_cnt), 32'h4);
        step(1,0,0,0,2'b00,1,1,0,0,0);
        chk("cmp_no_use_old", 32'(last_use), 32'h0);
        step(1,1,1,0,2'b00,0,0,0,0,0);
        step(0,0,0,1,2'b11,0,0,1,0,0);
        chk("kill_wins", 32'(bus.flag_old), 32'h2);
        chk("kill_valid", 32'(bus.flag_pending), 32'h0);
        step(1,1,1,0,2'b00,0,0,0,0,0);
        step(1,1,0,0,2'b01,0,0,0,0,0);
        chk("waw_stall", 32'(last_stall), 32'h1);
        step(1,1,0,1,2'b11,0,0,0,0,0);
        chk("waw_older", 32'(bus.flag_old), 32'h3);
        step(1,1,0,0,2'b01,0,0,0,0,0);
        chk("waw_younger", 32'(bus.flag_old), 32'h1);
        step(1,1,0,0,2'b11,0,0,0,1,0);
        chk("stall_in_hold", 32'(bus.flag_old), 32'h1);
        step(1,1,1,0,2'b00,0,0,0,0,0);
        step(1,0,0,1,2'b10,0,0,0,1,0);
        chk("mc_under_stall_in", 32'(bus.flag_old), 32'h2);
        step(1,1,1,0,2'b00,0,0,0,0,0);
        step(1,0,0,0,2'b00,1,0,0,0,0);
        step(1,0,0,0,2'b00,1,0,0,0,1);
        chk("rst_pend_flag", 32'(bus.flag_old), 32'h0);
        chk("rst_pend_state", 32'(bus.flag_pending), 32'h0);
        chk("rst_pend_cnt", 32'(bus.stall_cnt), 32'h0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0, ($urandom % 2) == 1, ($urandom % 3) == 0, ($urandom % 4) == 0,
                 2'($urandom), ($urandom % 2) == 1, ($urandom % 3) == 0, ($urandom % 10) == 0,
                 ($urandom % 5) == 0, ($urandom % 60) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
